debounce_gen: RTL and testbench
===============================

Name: debounce_gen

Overview:
Parametrised debouncer with edge detection for N asynchronous board inputs (pushbuttons, slider switches, external contacts).
- Each input is synchronised and sampled on a shared divided tick.
- An output changes only after SAMPLE_DEPTH consecutive identical samples.
- Each output change produces single-cycle rise/fall pulses, so GPIO and interrupt logic need no edge detection of their own.
- Sits between the board pins and the GPIO/peripheral register blocks.

Parameters:
CLK_FREQUENCY_HZ, 100_000_000, system clock frequency
DEBOUNCE_FREQUENCY_HZ, 250, sample tick rate
NUM_CHANNELS, 22, number of independent inputs (>=1)
SAMPLE_DEPTH, 4, consecutive equal samples required to change an output (>=2)
RESET_VALUE, {NUM_CHANNELS{1'b0}}, per-channel idle level loaded at reset (e.g. bit0=1 for active-low CPU reset button)
CNTR_WIDTH, 32, tick counter width; must hold TOP
SIMULATE, 0, 1 = use SIMULATE_FREQUENCY_CNT as TOP
SIMULATE_FREQUENCY_CNT, 5, TOP value when SIMULATE=1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
din  input  NUM_CHANNELS  raw asynchronous inputs
dout  output  NUM_CHANNELS  debounced levels (registered)
rise  output  NUM_CHANNELS  1-cycle pulse when dout[i] goes 0->1
fall  output  NUM_CHANNELS  1-cycle pulse when dout[i] goes 1->0
changed  output  1  OR of all rise|fall, same cycle
sample_tick  output  1  1-cycle strobe, high when samples are taken

Behaviour:
- One clock, reset is synchronous and active-high; all state updates on posedge clk.
- TOP = SIMULATE ? SIMULATE_FREQUENCY_CNT : CLK_FREQUENCY_HZ/DEBOUNCE_FREQUENCY_HZ - 1.

Tick counter:
- Counts 0..TOP, then wraps to 0.
- sample_tick is registered and high for exactly the one cycle after the counter equals TOP.
- Period is TOP+1 cycles.

Synchroniser:
- 2-flop per channel; sync_q is the second-stage output.

Shift register (SAMPLE_DEPTH bits per channel):
- On sample_tick: shreg <= {shreg[SAMPLE_DEPTH-2:0], sync_q}.
- Otherwise holds.

Output decision (evaluated every cycle):
- shreg all ones -> dout_next=1.
- shreg all zeros -> dout_next=0.
- Otherwise dout_next=dout (hold).

Pulse generation:
- dout <= dout_next.
- rise <= dout_next & ~dout.
- fall <= ~dout_next & dout.
- rise/fall assert in the same cycle the new dout value first appears, for exactly one cycle.
- At most one rise/fall per channel per tick.

Reset values:
- Counter = 0, sample_tick = 0.
- Sync flops and every shreg bit = RESET_VALUE[i]; dout = RESET_VALUE.
- rise = fall = 0, changed = 0.

Reset boundary conditions:
- Reset mid-operation discards partial sample history; a full SAMPLE_DEPTH fresh ticks are needed to change dout.
- No rise/fall pulses are generated by reset assertion or release, even if dout changes value because of reset.

Latency:
- From a stable din change to dout/pulse: 2 sync cycles + SAMPLE_DEPTH ticks (the first tick may be up to TOP+1 cycles away) + 1 cycle.
- Worst case: 2 + SAMPLE_DEPTH*(TOP+1) + 1 cycles.

Other boundaries:
- Any disagreeing sample restarts qualification.
- Channels are fully independent.
- Simultaneous changes on multiple channels pulse in the same cycle; changed is a single 1-cycle pulse.
- Counter wrap is exact: there is no tick skip or double tick at TOP.
- TOP=0 gives a tick every cycle; this is legal.

Test Plan:
All scenarios use SIMULATE=1, SIMULATE_FREQUENCY_CNT=5 (tick every 6 cycles), NUM_CHANNELS=4, SAMPLE_DEPTH=4.
1. Tick cadence: hold reset 3 cycles, release -> sample_tick high at cycle 6 after release, then every 6 cycles, width 1; reasserting reset clears the counter.
2. Reset value: RESET_VALUE=4'b0001, din=4'b0000 -> dout=0001 during reset with no pulses; after release, dout[0] falls after 4 ticks; fall[0]=1 for exactly 1 cycle; changed=1 that cycle.
3. Clean step: din[1] 0->1, held -> dout[1]=1 within 2+24+1 cycles; rise[1] single-cycle pulse aligned with dout[1] going high; no other pulses.
4. Bounce rejection: toggle din[2] every 7 cycles for 80 cycles, then hold 0 -> dout[2] stays 0 throughout; rise[2]/fall[2] never assert.
5. Reset mid-qualification: din[3]=1 stable for 3 ticks, 1-cycle reset pulse -> dout[3] stays 0; it rises only after 4 further ticks, with no pulse at the reset edge.
6. Simultaneous events: dout=0001; din changes to 1000 in one cycle -> fall[0] and rise[3] assert in the same cycle; changed is high for exactly that one cycle.

Source files
------------

// File: rtl/debounce_gen.sv
// Multi-channel debouncer: 2-flop synchronisers, a shared divided sample tick,
// SAMPLE_DEPTH-deep agreement filters and single-cycle rise/fall strobes.
module debounce_gen #(
  parameter int                      CLK_FREQUENCY_HZ       = 100_000_000,
  parameter int                      DEBOUNCE_FREQUENCY_HZ  = 250,
  parameter int                      NUM_CHANNELS           = 22,
  parameter int                      SAMPLE_DEPTH           = 4,
  parameter logic [NUM_CHANNELS-1:0] RESET_VALUE            = {NUM_CHANNELS{1'b0}},
  parameter int                      CNTR_WIDTH             = 32,
  parameter bit                      SIMULATE               = 1'b0,
  parameter int                      SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] din,
  output logic [NUM_CHANNELS-1:0] dout,
  output logic [NUM_CHANNELS-1:0] rise,
  output logic [NUM_CHANNELS-1:0] fall,
  output logic                    changed,
  output logic                    sample_tick
);

  localparam int TOP_INT = SIMULATE ? SIMULATE_FREQUENCY_CNT
                                    : (CLK_FREQUENCY_HZ / DEBOUNCE_FREQUENCY_HZ) - 1;
  localparam logic [CNTR_WIDTH-1:0] TOP = CNTR_WIDTH'(TOP_INT);

  logic [CNTR_WIDTH-1:0]   tick_cnt;
  logic [NUM_CHANNELS-1:0] sync_d;
  logic [NUM_CHANNELS-1:0] sync_q;
  logic [SAMPLE_DEPTH-1:0] shreg [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] dout_next;

  // The strobe is registered, so it lands the cycle after the counter hits TOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else if (tick_cnt == TOP) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b1;
    end else begin
      tick_cnt    <= tick_cnt + CNTR_WIDTH'(1);
      sample_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_d <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      sync_d <= din;
      sync_q <= sync_d;
    end
  end

  // Reset preloads the history with the idle level so old samples are forgotten.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_shreg
    always_ff @(posedge clk) begin
      if (reset) begin
        shreg[ch] <= {SAMPLE_DEPTH{RESET_VALUE[ch]}};
      end else if (sample_tick) begin
        shreg[ch] <= {shreg[ch][SAMPLE_DEPTH-2:0], sync_q[ch]};
      end
    end
  end

  always_comb begin
    dout_next = dout;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (&shreg[ch]) begin
        dout_next[ch] = 1'b1;
      end else if (~|shreg[ch]) begin
        dout_next[ch] = 1'b0;
      end
    end
  end

  // Reset forces the idle level directly, so it never produces edge strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= RESET_VALUE;
      rise <= '0;
      fall <= '0;
    end else begin
      dout <= dout_next;
      rise <= dout_next & ~dout;
      fall <= ~dout_next & dout;
    end
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_debounce_gen.sv
// Self-checking bench for debounce_gen: directed scenarios plus randomized din,
// all checked against a queue-based behavioural model of the sampling rules.
module tb_debounce_gen;

  localparam int             NCH    = 4;
  localparam int             DEPTH  = 4;
  localparam int             PERIOD = 6;
  localparam logic [NCH-1:0] RV     = 4'b0001;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] din;
  logic [NCH-1:0] dout;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic           changed;
  logic           sample_tick;

  debounce_gen #(
    .CLK_FREQUENCY_HZ      (100_000_000),
    .DEBOUNCE_FREQUENCY_HZ (250),
    .NUM_CHANNELS          (NCH),
    .SAMPLE_DEPTH          (DEPTH),
    .RESET_VALUE           (RV),
    .CNTR_WIDTH            (32),
    .SIMULATE              (1'b1),
    .SIMULATE_FREQUENCY_CNT(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .changed    (changed),
    .sample_tick(sample_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: edges since reset, a 2-deep delay line and the sample history.
  int             cyc;
  logic           m_tick;
  logic [NCH-1:0] sync_line[$];
  logic [NCH-1:0] samples[$];
  logic [NCH-1:0] m_dout;
  logic [NCH-1:0] m_rise;
  logic [NCH-1:0] m_fall;

  int             rise_cnt[NCH];
  int             fall_cnt[NCH];
  int             changed_cnt;
  logic [NCH-1:0] last_rise;
  logic [NCH-1:0] last_fall;

  task automatic model_step(input logic rst, input logic [NCH-1:0] d);
    logic [NCH-1:0] nd;
    bit all_one;
    bit all_zero;
    if (rst) begin
      cyc    = 0;
      m_tick = 1'b0;
      sync_line.delete();
      samples.delete();
      for (int k = 0; k < 2; k++) sync_line.push_back(RV);
      for (int k = 0; k < DEPTH; k++) samples.push_back(RV);
      m_dout = RV;
      m_rise = '0;
      m_fall = '0;
    end else begin
      nd = m_dout;
      for (int ch = 0; ch < NCH; ch++) begin
        all_one  = 1'b1;
        all_zero = 1'b1;
        foreach (samples[k]) begin
          if (samples[k][ch]) all_zero = 1'b0;
          else                all_one  = 1'b0;
        end
        if (all_one)       nd[ch] = 1'b1;
        else if (all_zero) nd[ch] = 1'b0;
      end
      m_rise = nd & ~m_dout;
      m_fall = ~nd & m_dout;
      m_dout = nd;
      if (m_tick) begin
        samples.push_back(sync_line[0]);
        if (samples.size() > DEPTH) void'(samples.pop_front());
      end
      void'(sync_line.pop_front());
      sync_line.push_back(d);
      cyc++;
      m_tick = ((cyc % PERIOD) == 0);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
      else begin
        n_err++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < NCH; ch++) begin
      rise_cnt[ch] = 0;
      fall_cnt[ch] = 0;
    end
    changed_cnt = 0;
    last_rise   = '0;
    last_fall   = '0;
  endtask

  // One clock: drive on the falling edge, advance the model, check just after the rising edge.
  task automatic applyStimulus(input logic rst, input logic [NCH-1:0] d);
    @(negedge clk);
    reset = rst;
    din   = d;
    @(posedge clk);
    model_step(rst, d);
    #1;
    checkOutput("dout",        32'(dout),        32'(m_dout));
    checkOutput("rise",        32'(rise),        32'(m_rise));
    checkOutput("fall",        32'(fall),        32'(m_fall));
    checkOutput("changed",     32'(changed),     32'(|(m_rise | m_fall)));
    checkOutput("sample_tick", 32'(sample_tick), 32'(m_tick));
    for (int ch = 0; ch < NCH; ch++) begin
      if (rise[ch] === 1'b1) rise_cnt[ch]++;
      if (fall[ch] === 1'b1) fall_cnt[ch]++;
    end
    if (changed === 1'b1) begin
      changed_cnt++;
      last_rise = rise;
      last_fall = fall;
    end
  endtask

  initial begin
    logic [NCH-1:0] d;
    int hold;
    reset = 1'b1;
    din   = '0;
    clear_counts();

    // Tick cadence, then reset clears the counter.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 4'b0000);
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b0, 4'b0000);
      checkOutput("tick_cadence", 32'(sample_tick), 32'((k % PERIOD) == 0));
    end
    applyStimulus(1'b1, 4'b0000);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, 4'b0000);
      checkOutput("tick_after_rst", 32'(sample_tick), 32'(k == PERIOD));
    end

    // Reset value 0001 with din idle low: one fall pulse after four ticks.
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("rst_dout", 32'(dout), 32'(4'b0001));
    checkOutput("rst_pulses", 32'(rise | fall), 32'(0));
    clear_counts();
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b0, 4'b0000);
      checkOutput("rv_dout0", 32'(dout[0]), 32'(k < 26));
    end
    checkOutput("rv_fall0_cnt", 32'(fall_cnt[0]), 32'(1));
    checkOutput("rv_changed_cnt", 32'(changed_cnt), 32'(1));

    // Clean step on channel 1.
    clear_counts();
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 4'b0010);
    checkOutput("step_dout", 32'(dout), 32'(4'b0010));
    checkOutput("step_rise1_cnt", 32'(rise_cnt[1]), 32'(1));
    checkOutput("step_changed_cnt", 32'(changed_cnt), 32'(1));

    // Bounce on channel 2 toggling every 7 cycles, then held low.
    clear_counts();
    d = 4'b0010;
    for (int k = 0; k < 80; k++) begin
      if ((k % 7) == 0) d[2] = ~d[2];
      applyStimulus(1'b0, d);
    end
    for (int k = 0; k < 30; k++) applyStimulus(1'b0, 4'b0010);
    checkOutput("bounce_dout", 32'(dout), 32'(4'b0010));
    checkOutput("bounce_pulses2", 32'(rise_cnt[2] + fall_cnt[2]), 32'(0));
    checkOutput("bounce_changed_cnt", 32'(changed_cnt), 32'(0));

    // Partial qualification on channel 3 wiped by a one-cycle reset.
    for (int k = 0; k < 19; k++) applyStimulus(1'b0, 4'b1010);
    checkOutput("partial_dout", 32'(dout), 32'(4'b0010));
    applyStimulus(1'b1, 4'b1010);
    checkOutput("midrst_dout", 32'(dout), 32'(4'b0001));
    checkOutput("midrst_pulses", 32'(rise | fall), 32'(0));
    clear_counts();
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 4'b1010);
      checkOutput("requal_dout3", 32'(dout[3]), 32'(k >= 26));
    end
    checkOutput("requal_rise3_cnt", 32'(rise_cnt[3]), 32'(1));

    // Simultaneous fall on channel 0 and rise on channel 3.
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 4'b0001);
    checkOutput("simul_pre_dout", 32'(dout), 32'(4'b0001));
    clear_counts();
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 4'b1000);
    checkOutput("simul_dout", 32'(dout), 32'(4'b1000));
    checkOutput("simul_changed_cnt", 32'(changed_cnt), 32'(1));
    checkOutput("simul_rise", 32'(last_rise), 32'(4'b1000));
    checkOutput("simul_fall", 32'(last_fall), 32'(4'b0001));

    // Randomized holds with occasional resets, checked cycle by cycle against the model.
    for (int seg = 0; seg < 60; seg++) begin
      d    = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 40);
      if ($urandom_range(0, 19) == 0) applyStimulus(1'b1, d);
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 9) == 0) applyStimulus(1'b0, d ^ 4'($urandom_range(1, 15)));
        else                           applyStimulus(1'b0, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
